// File: rtl/ppu_cpu_initiator.sv
// Host-request to NES CPU-bus master for the PPU register port, with INT -> one-clock NMI pulse.
// Define PPU_INIT_TOGGLE_RESET_EN to prepend a register-2 read (write-toggle clear) to SET_VADDR and VRAM_RD.
module ppu_cpu_initiator #(
    parameter int CYCLE_CLKS = 12,
    parameter int SETUP_CLKS = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_cmd,
    input  logic [2:0]  req_reg,
    input  logic [7:0]  req_data,
    input  logic [13:0] req_addr,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic [2:0]  CPU_A,
    inout  wire  [7:0]  CPU_D,
    output logic        RW,
    output logic        CS,
    input  logic        INT,
    output logic        nmi_pulse
);

    localparam int PH_W = $clog2(CYCLE_CLKS);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CYCLE_CLKS - 1);
    localparam logic [PH_W-1:0] PH_CS   = PH_W'(SETUP_CLKS);

`ifdef PPU_INIT_TOGGLE_RESET_EN
    localparam logic [2:0] SKIP = 3'd0;
`else
    localparam logic [2:0] SKIP = 3'd1;
`endif

    localparam logic [1:0] CMD_REG_RD    = 2'd0;
    localparam logic [1:0] CMD_REG_WR    = 2'd1;
    localparam logic [1:0] CMD_SET_VADDR = 2'd2;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

    state_t          state_q, state_d;
    logic [PH_W-1:0] ph_q, ph_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      rsp_data_q, rsp_data_d;
    logic            load;

    logic [1:0]      cmd_q;
    logic [2:0]      reg_q;
    logic [7:0]      wdat_q;
    logic [13:0]     addr_q;

    logic            acc_rd;
    logic [2:0]      acc_a;
    logic [7:0]      acc_wd;
    logic [2:0]      last_idx;
    logic [2:0]      step;

    logic            int_meta_q, int_sync_q, int_prev_q;
    logic            in_acc, cs_win;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            ph_q       <= '0;
            idx_q      <= '0;
            rsp_data_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            idx_q      <= idx_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Request fields are only consulted while a command is in flight, so they need no reset.
    always_ff @(posedge CLK) begin
        if (load) begin
            cmd_q  <= req_cmd;
            reg_q  <= req_reg;
            wdat_q <= req_data;
            addr_q <= req_addr;
        end
    end

    // The multi-access lists share one table; without the toggle read the table starts one entry later.
    always_comb begin
        acc_rd   = 1'b1;
        acc_a    = 3'd0;
        acc_wd   = 8'h00;
        last_idx = 3'd0;
        step     = idx_q + SKIP;
        case (cmd_q)
            CMD_REG_RD: begin
                acc_a = reg_q;
            end
            CMD_REG_WR: begin
                acc_rd = 1'b0;
                acc_a  = reg_q;
                acc_wd = wdat_q;
            end
            default: begin
                last_idx = ((cmd_q == CMD_SET_VADDR) ? 3'd2 : 3'd4) - SKIP;
                case (step)
                    3'd0: acc_a = 3'd2;
                    3'd1: begin
                        acc_rd = 1'b0;
                        acc_a  = 3'd6;
                        acc_wd = {2'b00, addr_q[13:8]};
                    end
                    3'd2: begin
                        acc_rd = 1'b0;
                        acc_a  = 3'd6;
                        acc_wd = addr_q[7:0];
                    end
                    default: acc_a = 3'd7;
                endcase
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        idx_d      = idx_q;
        rsp_data_d = rsp_data_q;
        load       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    load    = 1'b1;
                    state_d = ST_ACCESS;
                    ph_d    = '0;
                    idx_d   = '0;
                end
            end
            ST_ACCESS: begin
                if (ph_q == PH_LAST) begin
                    ph_d = '0;
                    if (idx_q == last_idx) begin
                        state_d    = ST_DONE;
                        rsp_data_d = acc_rd ? CPU_D : 8'h00;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus pins decode straight from state so an asynchronous reset idles the bus at once.
    assign in_acc    = (state_q == ST_ACCESS);
    assign cs_win    = in_acc && (ph_q >= PH_CS);
    assign CS        = ~cs_win;
    assign RW        = in_acc ? acc_rd : 1'b1;
    assign CPU_A     = in_acc ? acc_a : 3'd0;
    assign CPU_D     = (cs_win && !acc_rd) ? acc_wd : 8'hzz;
    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_DONE);
    assign rsp_data  = rsp_data_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            int_meta_q <= 1'b1;
            int_sync_q <= 1'b1;
            int_prev_q <= 1'b1;
        end else begin
            int_meta_q <= INT;
            int_sync_q <= int_meta_q;
            int_prev_q <= int_sync_q;
        end
    end

    assign nmi_pulse = int_prev_q & ~int_sync_q;

endmodule
